// File: rtl/dp_pkg.sv
// Shared widths, ACC input select encoding and ALU opcodes for the
// accumulator datapath.
package dp_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int OPERAND_WIDTH = 11;

  typedef enum logic [1:0] {
    SEL_A_MEM  = 2'b00,
    SEL_A_EXT  = 2'b01,
    SEL_A_ALU  = 2'b10,
    SEL_A_HOLD = 2'b11
  } sel_a_e;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/datapath_alu.sv
// Combinational add/subtract unit with zero and negative indications.
module alu
  import dp_pkg::*;
(
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  negative
);

  always_comb begin
    if (op == ALU_SUB) result = a - b;
    else               result = a + b;
  end

  assign zero     = (result == '0);
  assign negative = result[DATA_WIDTH-1];

endmodule

// File: rtl/datapath.sv
// Accumulator datapath: ACC, add/sub ALU, operand sign-extender, ACC input
// mux, ALU B mux and Z/N status register. Sequencing lives in the control unit.
module datapath
  import dp_pkg::*;
(
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic [OPERAND_WIDTH-1:0] operand_in,
  input  logic [DATA_WIDTH-1:0]    data_memory_in,
  input  logic                     alu_op_in,
  input  logic [1:0]               sel_A_in,
  input  logic                     sel_B_in,
  input  logic                     acc_wr_in,
  input  logic                     acc_reset_in,
  input  logic                     status_wr_in,
  input  logic                     status_reset_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [DATA_WIDTH-1:0]    ext_out,
  output logic [OPERAND_WIDTH-1:0] data_memory_address_out,
  output logic                     flag_Z_out,
  output logic                     flag_N_out
);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] acc_next;
  logic                  alu_zero;
  logic                  alu_negative;
  logic                  flag_z;
  logic                  flag_n;

  assign ext_out = {{(DATA_WIDTH-OPERAND_WIDTH){operand_in[OPERAND_WIDTH-1]}}, operand_in};
  assign alu_b   = sel_B_in ? ext_out : data_memory_in;

  alu u_alu (
    .op       (alu_op_in),
    .a        (acc),
    .b        (alu_b),
    .result   (alu_result),
    .zero     (alu_zero),
    .negative (alu_negative)
  );

  always_comb begin
    acc_next = acc;
    case (sel_A_in)
      SEL_A_MEM:  acc_next = data_memory_in;
      SEL_A_EXT:  acc_next = ext_out;
      SEL_A_ALU:  acc_next = alu_result;
      SEL_A_HOLD: acc_next = acc;
      default:    acc_next = acc;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in)      acc <= '0;
    else if (acc_reset_in) acc <= '0;
    else if (acc_wr_in)    acc <= acc_next;
  end

  // Flags sample the ALU result, so they describe the ACC write only when sel_A selects the ALU.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (status_reset_in) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (status_wr_in) begin
      flag_z <= alu_zero;
      flag_n <= alu_negative;
    end
  end

  assign data_out                = acc;
  assign data_memory_address_out = operand_in;
  assign flag_Z_out              = flag_z;
  assign flag_N_out              = flag_n;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the accumulator datapath.
module tb_datapath;

  logic        clock_in = 1'b0;
  logic        reset_n_in;
  logic [10:0] operand_in;
  logic [15:0] data_memory_in;
  logic        alu_op_in;
  logic [1:0]  sel_A_in;
  logic        sel_B_in;
  logic        acc_wr_in;
  logic        acc_reset_in;
  logic        status_wr_in;
  logic        status_reset_in;
  logic [15:0] data_out;
  logic [15:0] ext_out;
  logic [10:0] data_memory_address_out;
  logic        flag_Z_out;
  logic        flag_N_out;

  int tests  = 0;
  int failed = 0;

  always #5 clock_in = ~clock_in;

  datapath dut (
    .clock_in                (clock_in),
    .reset_n_in              (reset_n_in),
    .operand_in              (operand_in),
    .data_memory_in          (data_memory_in),
    .alu_op_in               (alu_op_in),
    .sel_A_in                (sel_A_in),
    .sel_B_in                (sel_B_in),
    .acc_wr_in               (acc_wr_in),
    .acc_reset_in            (acc_reset_in),
    .status_wr_in            (status_wr_in),
    .status_reset_in         (status_reset_in),
    .data_out                (data_out),
    .ext_out                 (ext_out),
    .data_memory_address_out (data_memory_address_out),
    .flag_Z_out              (flag_Z_out),
    .flag_N_out              (flag_N_out)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, input logic n);
    check({tag, "_z"}, {15'd0, flag_Z_out}, {15'd0, z});
    check({tag, "_n"}, {15'd0, flag_N_out}, {15'd0, n});
  endtask

  // One rising edge with the current strobes, then drop all strobes.
  task automatic pulse();
    @(posedge clock_in);
    #1;
    acc_wr_in       = 1'b0;
    acc_reset_in    = 1'b0;
    status_wr_in    = 1'b0;
    status_reset_in = 1'b0;
  endtask

  initial begin
    reset_n_in      = 1'b0;
    operand_in      = 11'h000;
    data_memory_in  = 16'h0000;
    alu_op_in       = 1'b0;
    sel_A_in        = 2'b00;
    sel_B_in        = 1'b0;
    acc_wr_in       = 1'b0;
    acc_reset_in    = 1'b0;
    status_wr_in    = 1'b0;
    status_reset_in = 1'b0;
    #3;
    check("reset_acc", data_out, 16'h0000);
    check("reset_ext", ext_out, 16'h0000);
    check_flags("reset", 1'b0, 1'b0);

    @(posedge clock_in); #1;
    reset_n_in = 1'b1;

    // ACC=0 + mem 0x8000 -> N=1, ACC loads 0x8000 from memory
    data_memory_in = 16'h8000; sel_A_in = 2'b00; sel_B_in = 1'b0; alu_op_in = 1'b0;
    acc_wr_in = 1'b1; status_wr_in = 1'b1;
    pulse();
    check("preload_acc", data_out, 16'h8000);
    check_flags("preload", 1'b0, 1'b1);

    #2;
    reset_n_in = 1'b0;
    #1;
    check("async_reset_acc", data_out, 16'h0000);
    check_flags("async_reset", 1'b0, 1'b0);
    #1;
    reset_n_in = 1'b1;

    operand_in = 11'h001; data_memory_in = 16'h0001; sel_A_in = 2'b00; acc_wr_in = 1'b1;
    pulse();
    check("load_mem_acc", data_out, 16'h0001);
    check("load_mem_addr", {5'd0, data_memory_address_out}, 16'h0001);
    check("load_mem_ext", ext_out, 16'h0001);
    check_flags("load_mem", 1'b0, 1'b0);

    alu_op_in = 1'b1; sel_B_in = 1'b0; sel_A_in = 2'b10; status_wr_in = 1'b1;
    pulse();
    check_flags("sub_flags", 1'b1, 1'b0);
    check("sub_acc_unchanged", data_out, 16'h0001);
    acc_wr_in = 1'b1;
    pulse();
    check("sub_acc", data_out, 16'h0000);
    check_flags("sub_acc_only", 1'b1, 1'b0);

    operand_in = 11'h7FF;
    #1;
    check("ext_7ff", ext_out, 16'hFFFF);
    sel_B_in = 1'b1; alu_op_in = 1'b0; sel_A_in = 2'b10; acc_wr_in = 1'b1; status_wr_in = 1'b1;
    pulse();
    check("imm_acc", data_out, 16'hFFFF);
    check_flags("imm", 1'b0, 1'b1);

    sel_B_in = 1'b0; data_memory_in = 16'h0001; alu_op_in = 1'b0; sel_A_in = 2'b10;
    acc_wr_in = 1'b1; status_wr_in = 1'b1;
    pulse();
    check("wrap_acc", data_out, 16'h0000);
    check_flags("wrap", 1'b1, 1'b0);

    data_memory_in = 16'h0055; sel_A_in = 2'b00; acc_wr_in = 1'b1;
    pulse();
    check("load_55", data_out, 16'h0055);
    data_memory_in = 16'h0077; acc_reset_in = 1'b1; acc_wr_in = 1'b1;
    pulse();
    check("acc_reset_prio", data_out, 16'h0000);

    data_memory_in = 16'h0055; sel_A_in = 2'b00; acc_wr_in = 1'b1;
    pulse();
    data_memory_in = 16'hAAAA; sel_A_in = 2'b11; acc_wr_in = 1'b1;
    pulse();
    check("hold_sel", data_out, 16'h0055);

    // 0x0055 - 0x0100 = 0xFF55
    data_memory_in = 16'h0100; sel_B_in = 1'b0; alu_op_in = 1'b1; status_wr_in = 1'b1;
    pulse();
    check_flags("neg_sub", 1'b0, 1'b1);
    check("neg_sub_acc", data_out, 16'h0055);
    status_reset_in = 1'b1; status_wr_in = 1'b1;
    pulse();
    check_flags("status_reset_prio", 1'b0, 1'b0);

    // Undefined controls with enables low must leave state alone
    sel_A_in = 2'bxx; alu_op_in = 1'bx; sel_B_in = 1'bx; data_memory_in = 16'hxxxx;
    @(posedge clock_in); #1;
    check("x_hold_acc", data_out, 16'h0055);
    check_flags("x_hold", 1'b0, 1'b0);
    sel_A_in = 2'b00; alu_op_in = 1'b0; sel_B_in = 1'b0; data_memory_in = 16'h0000;

    operand_in = 11'h3FF; #1;
    check("addr_3ff", {5'd0, data_memory_address_out}, 16'h03FF);
    check("ext_3ff", ext_out, 16'h03FF);
    operand_in = 11'h400; #1;
    check("addr_400", {5'd0, data_memory_address_out}, 16'h0400);
    check("ext_400", ext_out, 16'hFC00);
    operand_in = 11'h123; #1;
    check("addr_123", {5'd0, data_memory_address_out}, 16'h0123);
    check("ext_123", ext_out, 16'h0123);

    sel_A_in = 2'b01; acc_wr_in = 1'b1;
    pulse();
    check("load_ext", data_out, 16'h0123);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Accumulator-based datapath of the team's small accumulator processor core, driven by the control unit.
- Contains a 16-bit accumulator (ACC), an add/subtract ALU, an operand sign-extender, the ACC input mux, the ALU B-operand mux and a 2-bit status register (Z, N).
- Outputs the ACC value as memory write data, the instruction operand as the data-memory address, and the flags for branch decisions.

Parameters:
- OPERAND_WIDTH, 11, width of the instruction operand/immediate and of the data-memory address; must be < DATA_WIDTH.
- DATA_WIDTH, 16, width of data memory words, ACC, ALU and extended operand.

Ports:
- clock_in  input  1  system clock; all state updates on the rising edge.
- reset_n_in  input  1  asynchronous active-low reset for ACC and status register.
- operand_in  input  OPERAND_WIDTH  instruction operand (immediate or address).
- data_memory_in  input  DATA_WIDTH  word read from data memory.
- alu_op_in  input  1  ALU operation: 0 = add, 1 = subtract.
- sel_A_in  input  2  ACC input select.
- sel_B_in  input  1  ALU B select.
- acc_wr_in  input  1  ACC load enable.
- acc_reset_in  input  1  synchronous active-high ACC clear.
- status_wr_in  input  1  status register load enable.
- status_reset_in  input  1  synchronous active-high status clear.
- data_out  output  DATA_WIDTH  current ACC value (memory write data).
- ext_out  output  DATA_WIDTH  sign-extended operand_in.
- data_memory_address_out  output  OPERAND_WIDTH  equals operand_in, combinational.
- flag_Z_out  output  1  registered zero flag.
- flag_N_out  output  1  registered negative flag.

Behaviour:
- Reset: reset_n_in=0 immediately forces ACC=0, Z=0, N=0, independent of the clock. With operand_in=0 this gives data_out=0 and ext_out=0.
- ext_out: {(DATA_WIDTH-OPERAND_WIDTH){operand_in[OPERAND_WIDTH-1]}, operand_in}. Combinational.
- ALU A is ACC. ALU B = sel_B_in ? ext_out : data_memory_in.
- ALU result: alu_op_in=0 gives A+B; alu_op_in=1 gives A-B. Both are modulo 2^DATA_WIDTH, with no carry or overflow output. Combinational.
- Flag values: Z = (result == 0); N = result[DATA_WIDTH-1].
- ACC next-value mux, by sel_A_in:
  - 00: data_memory_in.
  - 01: ext_out.
  - 10: ALU result.
  - 11: current ACC (hold).
- ACC update, rising edge, in priority order: acc_reset_in=1 clears to 0; else acc_wr_in=1 loads the mux output; else hold.
- Status update, rising edge, in priority order: status_reset_in=1 clears Z and N to 0; else status_wr_in=1 loads Z and N from the current ALU result; else hold.
- Flags reflect the ALU result, not the ACC mux output. Writing ACC alone leaves the flags unchanged.
- acc_wr_in and status_wr_in in the same cycle: both capture from the same pre-edge ACC. Flags describe the value being written to ACC when sel_A_in=10.
- Latency:
  - data_out and the flags change one edge after the write strobe.
  - ext_out and data_memory_address_out have zero latency.
- Control inputs that are X/undefined while their enable is 0 must not corrupt state.
- No internal FSM; sequencing is owned by the control unit.

Decomposition:
- Shared package (dp_pkg):
  - Parameters DATA_WIDTH and OPERAND_WIDTH.
  - Enum for sel_A (SEL_A_MEM=2'b00, SEL_A_EXT=2'b01, SEL_A_ALU=2'b10, SEL_A_HOLD=2'b11).
  - Constants ALU_ADD=1'b0 and ALU_SUB=1'b1.
- One natural sub-module: alu, combinational add/sub producing the result plus zero and negative indications.
- Clock source for simulation comes from the shared clock_generator bench model. It is free-running, 50% duty, and not synthesised.

Test Plan:
- Async reset: hold reset_n_in=0 mid-cycle -> data_out=0, flag_Z_out=0, flag_N_out=0 without waiting for an edge.
- Load memory: operand_in=11'h001, data_memory_in=16'h0001, sel_A_in=00, acc_wr_in pulse -> data_out=16'h0001, flags unchanged at 0.
- Subtract and flag: from ACC=1 with data_memory_in=1, alu_op_in=1, sel_B_in=0, sel_A_in=10:
  - status_wr_in pulse -> Z=1, N=0.
  - Then acc_wr_in pulse -> data_out=0.
- Immediate/extension: operand_in=11'h7FF -> ext_out=16'hFFFF. With ACC=0, sel_B_in=1, alu_op_in=0, sel_A_in=10, simultaneous acc_wr_in and status_wr_in -> data_out=16'hFFFF, N=1, Z=0.
- Wrap-around: ACC=16'hFFFF, data_memory_in=16'h0001, add, acc_wr_in and status_wr_in -> data_out=0, Z=1, N=0.
- Priority/hold: with acc_reset_in=1 and acc_wr_in=1 on the same edge -> ACC=0. With sel_A_in=11 and acc_wr_in=1 -> ACC unchanged. With status_reset_in=1 and status_wr_in=1 -> Z=0, N=0. data_memory_address_out tracks operand_in on every change.
